uart_trx_core: RTL
==================

Name: uart_trx_core

Overview:
- Synthesizable, runtime-configurable UART transmitter and receiver engine. It is the RTL successor of the bench-side UART model.
- Runtime options: data bits 5–8, optional even/odd parity, 1 or 2 stop bits, programmable baud divisor, oversampled receiver.
- Sits under the APB UART register/FIFO layer. It exchanges bytes through valid/ready handshakes and drives/samples the physical tx/rx pins.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit (even, ≥4).
- DIV_W, 16, width of the baud divisor.
- SYNC_STAGES, 2, rx_i synchronizer depth (≥2).

Ports:
- clk_i  in  1  core clock
- arst_ni  in  1  asynchronous active-low reset
- cfg_clk_div_i  in  DIV_W  core clocks per oversample tick; 0 is treated as 1
- cfg_data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
- cfg_parity_en_i  in  1  parity bit present
- cfg_parity_type_i  in  1  0=even, 1=odd
- cfg_two_stop_i  in  1  1 = two stop bits
- tx_data_i  in  8  byte to send, LSB first; unused MSBs ignored
- tx_valid_i  in  1  tx byte offered
- tx_ready_o  out  1  core can accept a tx byte
- tx_o  out  1  serial line out, idle high
- tx_busy_o  out  1  tx frame in progress
- rx_i  in  1  serial line in, asynchronous
- rx_data_o  out  8  received byte, unused MSBs zero
- rx_valid_o  out  1  rx_data_o and error flags valid
- rx_ready_i  in  1  consumer accepts rx byte
- rx_parity_err_o  out  1  parity mismatch; qualified by rx_valid_o
- rx_frame_err_o  out  1  stop bit sampled low; qualified by rx_valid_o
- rx_overrun_o  out  1  one-cycle pulse: completed frame dropped
- rx_busy_o  out  1  rx frame in progress

Behaviour:
- Reset values:
  - tx_o=1, tx_ready_o=1, tx_busy_o=0.
  - rx_valid_o=0, rx_data_o=0, all error outputs=0, rx_busy_o=0.
  - Synchronizer flops reset to 1.
- Reset mid-frame: tx_o returns high asynchronously; the partial rx frame is discarded.
- Tick generator:
  - Free-running counter; tick pulses one cycle every max(cfg_clk_div_i,1) clocks.
  - One bit time = OVERSAMPLE ticks.
  - Counter restarts when a tx or rx frame starts, so bit timing is phase-aligned.
- Config latch: all config inputs are captured at frame start, separately for TX and RX. Changes mid-frame take effect on the next frame.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE.
  - Handshake: tx_valid_i && tx_ready_o in IDLE latches the byte. tx_ready_o deasserts the next cycle and tx_o goes low the same cycle the FSM enters START.
  - Each state lasts OVERSAMPLE ticks.
  - Parity bit = XOR of the active data bits, inverted if odd.
  - tx_ready_o reasserts the cycle after the last stop bit ends. Back-to-back frames therefore have zero idle bits.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE. It operates on the synchronized rx_i.
  - A falling edge in IDLE enters START.
  - At tick OVERSAMPLE/2 the line is re-checked. If high: glitch, return to IDLE with no output.
  - Data, parity and stop bits are sampled every OVERSAMPLE ticks after the mid-start point. Data fills from bit 0.
  - Parity check uses the same rule as TX. A stop bit sampled 0 sets frame_err.
  - Only the first stop bit is checked. RX returns to IDLE at mid-stop, so it can catch the next start bit.
- RX output register:
  - The frame completes at mid-stop. Data and both error flags load, and rx_valid_o rises the next cycle.
  - The register holds until rx_valid_o && rx_ready_i; rx_valid_o falls the cycle after acceptance.
  - If a frame completes while rx_valid_o=1 and not accepted in that same cycle: the new frame is dropped, held data is unchanged, and rx_overrun_o pulses for one cycle.
  - If a frame completes in the same cycle the held byte is accepted: the new frame loads and rx_valid_o stays high.

Decomposition:
- Package uart_pkg holds:
  - enum data_bits_e;
  - struct uart_cfg_t {div, data_bits, parity_en, parity_type, two_stop};
  - function parity_calc(data, bits, type);
  - the TX and RX state enums.
- One sub-module, uart_baud_tick: divisor counter with a restart input.
- TX and RX engines stay inline.

Test Plan:
- div=1, 8N1, send 0x55:
  - tx_o low 16 clocks, then bits 1,0,1,0,1,0,1,0 of 16 clocks each, then high 16 clocks.
  - tx_ready_o low for exactly 160 clocks.
- Loopback tx_o→rx_i, div=3, 8O1, byte 0xA5:
  - parity bit sent = 1;
  - rx_data_o=0xA5, parity_err=0, frame_err=0, rx_valid_o held until rx_ready_i.
- 7E2, send 0xFF:
  - tx sends 7 ones and parity 1, then high for 32 ticks;
  - receiver gets rx_data_o=0x7F.
- Bench drives 8N1 frame 0x3C with stop bit forced 0: rx_valid_o=1, rx_data_o=0x3C, rx_frame_err_o=1.
- Bench drives 8E1 0x01 with parity bit 0: rx_parity_err_o=1.
- Two frames 0x11, 0x22 with rx_ready_i=0:
  - rx_data_o stays 0x11;
  - rx_overrun_o pulses once at the second mid-stop;
  - a 5-tick low glitch on rx_i produces no rx_valid_o.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive engine.
package uart_pkg;

  // Widest baud divisor a configuration snapshot can hold.
  localparam int unsigned CFG_DIV_W = 32;

  typedef enum logic [1:0] {
    DATA_BITS_5 = 2'b00,
    DATA_BITS_6 = 2'b01,
    DATA_BITS_7 = 2'b10,
    DATA_BITS_8 = 2'b11
  } data_bits_e;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    data_bits_e           data_bits;
    logic                 parity_en;
    logic                 parity_type;
    logic                 two_stop;
  } uart_cfg_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Mask selecting the active data bits of a byte.
  function automatic logic [7:0] data_mask(input data_bits_e bits);
    return 8'hFF >> (2'd3 - bits);
  endfunction

  // Index of the last data bit sent/received (4 for 5 bits .. 7 for 8 bits).
  function automatic logic [2:0] last_bit_idx(input data_bits_e bits);
    return 3'd4 + {1'b0, bits};
  endfunction

  // XOR of the active data bits, inverted for odd parity.
  function automatic logic parity_calc(input logic [7:0] data, input data_bits_e bits,
                                       input logic odd);
    return (^(data & data_mask(bits))) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every max(div,1) clocks,
// restartable so a new frame starts on a fresh tick phase.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 restart_i,
  input  logic [CFG_DIV_W-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [CFG_DIV_W-1:0] last_cnt;

  // A divisor of zero behaves like one: tick every clock.
  assign last_cnt = (div_i == '0) ? '0 : div_i - CFG_DIV_W'(1);
  assign tick_o   = (CFG_DIV_W'(cnt_q) >= last_cnt);

  // Next count: wrap on tick, clear on restart.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_trx_core.sv
// UART transmit and receive engine with runtime frame format, per-direction
// configuration snapshot and an oversampled, synchronized receiver.
module uart_trx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic [DIV_W-1:0] cfg_clk_div_i,
  input  logic [1:0]       cfg_data_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_parity_type_i,
  input  logic             cfg_two_stop_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             tx_o,
  output logic             tx_busy_o,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_parity_err_o,
  output logic             rx_frame_err_o,
  output logic             rx_overrun_o,
  output logic             rx_busy_o
);

  localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  uart_cfg_t cfg_now;

  // Live configuration packed for snapshotting at frame start.
  always_comb begin
    cfg_now             = '0;
    cfg_now.div         = CFG_DIV_W'(cfg_clk_div_i);
    cfg_now.data_bits   = data_bits_e'(cfg_data_bits_i);
    cfg_now.parity_en   = cfg_parity_en_i;
    cfg_now.parity_type = cfg_parity_type_i;
    cfg_now.two_stop    = cfg_two_stop_i;
  end

  // ---------------------------------------------------------------- TX
  tx_state_e       tx_state_q;
  uart_cfg_t       tx_cfg_q;
  logic [7:0]      tx_data_q;
  logic [2:0]      tx_bit_q;
  logic [OS_W-1:0] tx_os_q;
  logic            tx_o_q, tx_ready_q;
  logic            tx_tick, tx_start, tx_bit_end;

  assign tx_start   = (tx_state_q == TX_IDLE) && tx_valid_i && tx_ready_q;
  assign tx_bit_end = tx_tick && (tx_os_q == OS_LAST);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tx_tick (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .restart_i (tx_start),
    .div_i     (tx_cfg_q.div),
    .tick_o    (tx_tick)
  );

  // TX frame sequencer; each state is one bit time, line driven from a register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cfg_q   <= '0;
      tx_data_q  <= '0;
      tx_bit_q   <= '0;
      tx_os_q    <= '0;
      tx_o_q     <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      if ((tx_state_q != TX_IDLE) && tx_tick) tx_os_q <= tx_bit_end ? '0 : tx_os_q + OS_W'(1);
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_start) begin
            tx_cfg_q   <= cfg_now;
            tx_data_q  <= tx_data_i;
            tx_bit_q   <= '0;
            tx_os_q    <= '0;
            tx_o_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_o_q     <= tx_data_q[0];
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == last_bit_idx(tx_cfg_q.data_bits)) begin
              if (tx_cfg_q.parity_en) begin
                tx_o_q     <= parity_calc(tx_data_q, tx_cfg_q.data_bits, tx_cfg_q.parity_type);
                tx_state_q <= TX_PARITY;
              end else begin
                tx_o_q     <= 1'b1;
                tx_state_q <= TX_STOP1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_o_q   <= tx_data_q[tx_bit_q + 3'd1];
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_o_q     <= 1'b1;
            tx_state_q <= TX_STOP1;
          end
        end
        TX_STOP1: begin
          if (tx_bit_end) begin
            if (tx_cfg_q.two_stop) begin
              tx_state_q <= TX_STOP2;
            end else begin
              tx_ready_q <= 1'b1;
              tx_state_q <= TX_IDLE;
            end
          end
        end
        TX_STOP2: begin
          if (tx_bit_end) begin
            tx_ready_q <= 1'b1;
            tx_state_q <= TX_IDLE;
          end
        end
        default: begin
          tx_o_q     <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_o       = tx_o_q;
  assign tx_ready_o = tx_ready_q;
  assign tx_busy_o  = (tx_state_q != TX_IDLE);

  // ---------------------------------------------------------------- RX
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   rx_prev_q;
  logic                   rx_s, rx_fall;

  // Metastability synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_sync_q <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s    = rx_sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q && !rx_s;

  rx_state_e            rx_state_q;
  logic [CFG_DIV_W-1:0] rx_div_q;
  data_bits_e           rx_bits_q;
  logic                 rx_par_en_q, rx_par_odd_q;
  logic [7:0]           rx_shift_q;
  logic [2:0]           rx_bit_q;
  logic [OS_W-1:0]      rx_os_q;
  logic                 rx_perr_q;
  logic                 rx_tick, rx_start, rx_sample, rx_done;

  assign rx_start  = (rx_state_q == RX_IDLE) && rx_fall;
  assign rx_sample = rx_tick && (rx_os_q == OS_LAST);
  assign rx_done   = (rx_state_q == RX_STOP) && rx_sample;

  uart_baud_tick #(.DIV_W(DIV_W)) u_rx_tick (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .restart_i (rx_start),
    .div_i     (rx_div_q),
    .tick_o    (rx_tick)
  );

  // RX frame sequencer; mid-start re-check, then one sample per bit time.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_state_q   <= RX_IDLE;
      rx_div_q     <= '0;
      rx_bits_q    <= DATA_BITS_5;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_shift_q   <= '0;
      rx_bit_q     <= '0;
      rx_os_q      <= '0;
      rx_perr_q    <= 1'b0;
    end else begin
      if ((rx_state_q != RX_IDLE) && rx_tick) rx_os_q <= rx_sample ? '0 : rx_os_q + OS_W'(1);
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_div_q     <= cfg_now.div;
            rx_bits_q    <= cfg_now.data_bits;
            rx_par_en_q  <= cfg_now.parity_en;
            rx_par_odd_q <= cfg_now.parity_type;
            rx_shift_q   <= '0;
            rx_bit_q     <= '0;
            rx_os_q      <= '0;
            rx_perr_q    <= 1'b0;
            rx_state_q   <= RX_START;
          end
        end
        RX_START: begin
          // Restarting the count here puts all later samples at bit centres.
          if (rx_tick && (rx_os_q == OS_MID)) begin
            rx_os_q    <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift_q[rx_bit_q] <= rx_s;
            if (rx_bit_q == last_bit_idx(rx_bits_q)) begin
              rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_perr_q  <= parity_calc(rx_shift_q, rx_bits_q, rx_par_odd_q) ^ rx_s;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  logic [7:0] rx_data_q;
  logic       rx_valid_q, rx_perr_out_q, rx_ferr_q, rx_ovr_q;

  // Output holding register with drop-on-overrun.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_done) begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_q     <= rx_shift_q;
          rx_perr_out_q <= rx_perr_q;
          rx_ferr_q     <= !rx_s;
          rx_valid_q    <= 1'b1;
        end else begin
          rx_ovr_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_out_q;
  assign rx_frame_err_o  = rx_ferr_q;
  assign rx_overrun_o    = rx_ovr_q;
  assign rx_busy_o       = (rx_state_q != RX_IDLE);

endmodule
